// File: rtl/x_serializer.sv
// Parallel-in/serial-out stage feeding the sequence FSM's x input, MSB first,
// with a load/ready handshake for gapless streaming. Optional macro: SER_PARITY_EN.
module x_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             x,
    output logic             busy,
    output logic             done
);

`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n, fill;
    logic [CW-1:0]    cnt, cnt_n;
    logic             x_n, busy_n, done_n;
    logic             last;

    // Bits still to send after the MSB goes straight to x; the parity bit
    // rides in the vacated LSB so it simply shifts out after din[0].
`ifdef SER_PARITY_EN
    assign fill = {din[WIDTH-2:0], ^din};
`else
    assign fill = {din[WIDTH-2:0], 1'b0};
`endif

    assign last  = (state == SHIFT) && (cnt == CW'(FRAME));
    assign ready = (state == IDLE) || last;

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        x_n     = x;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                x_n = 1'b0;
                if (load) begin
                    state_n = SHIFT;
                    shreg_n = fill;
                    cnt_n   = CW'(1);
                    x_n     = din[WIDTH-1];
                    busy_n  = 1'b1;
                end
            end
            SHIFT: begin
                if (last) begin
                    done_n = 1'b1;
                    if (load) begin
                        shreg_n = fill;
                        cnt_n   = CW'(1);
                        x_n     = din[WIDTH-1];
                    end else begin
                        state_n = IDLE;
                        shreg_n = '0;
                        cnt_n   = '0;
                        x_n     = 1'b0;
                        busy_n  = 1'b0;
                    end
                end else begin
                    x_n     = shreg[WIDTH-1];
                    shreg_n = {shreg[WIDTH-2:0], 1'b0};
                    cnt_n   = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                x_n     = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            x     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
            x     <= x_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_x_serializer.sv
// Directed bench for x_serializer (WIDTH=8); honours SER_PARITY_EN like the DUT.
module tb_x_serializer;

`ifdef SER_PARITY_EN
    localparam int FR = 9;
`else
    localparam int FR = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ready, x, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    x_serializer #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .din   (din),
        .ready (ready),
        .x     (x),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected x on cycle c (1-based) of a frame carrying w.
    function automatic logic exp_bit(input logic [7:0] w, input int c);
        if (c <= 8) return w[8-c];
        return ^w;
    endfunction

    // Load w from IDLE, check every bit cycle and the done cycle after it.
    task automatic run_frame(input logic [7:0] w, input string tag);
        @(negedge clk);
        chk({tag, " ready_idle"}, ready, 1'b1);
        load = 1'b1;
        din  = w;
        for (int c = 1; c <= FR + 2; c++) begin
            @(negedge clk);
            load = 1'b0;
            din  = ~w;
            if (c <= FR) begin
                chk($sformatf("%s x[%0d]", tag, c), x, exp_bit(w, c));
                chk($sformatf("%s busy[%0d]", tag, c), busy, 1'b1);
                chk($sformatf("%s done[%0d]", tag, c), done, 1'b0);
                chk($sformatf("%s ready[%0d]", tag, c), ready, (c == FR));
            end else if (c == FR + 1) begin
                chk({tag, " done_pulse"}, done, 1'b1);
                chk({tag, " busy_end"}, busy, 1'b0);
                chk({tag, " x_end"}, x, 1'b0);
                chk({tag, " ready_end"}, ready, 1'b1);
            end else begin
                chk({tag, " done_clear"}, done, 1'b0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst x", x, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst ready", ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;

        // Single frame, MSB first
        run_frame(8'b1011_0010, "b2");
        run_frame(8'h07, "07");

        // Back-to-back: FF then 00 with no gap
        @(negedge clk);
        load = 1'b1;
        din  = 8'hFF;
        for (int c = 1; c <= 2 * FR + 2; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (c <= 2 * FR) begin
                chk($sformatf("b2b x[%0d]", c), x, (c <= FR) ? exp_bit(8'hFF, c) : exp_bit(8'h00, c - FR));
                chk($sformatf("b2b busy[%0d]", c), busy, 1'b1);
            end else begin
                chk("b2b busy_end", busy, 1'b0);
            end
            chk($sformatf("b2b done[%0d]", c), done, (c == FR + 1 || c == 2 * FR + 1));
            if (c == FR) begin
                chk("b2b ready_last", ready, 1'b1);
                load = 1'b1;
                din  = 8'h00;
            end
        end

        // Load while busy (ready=0) is ignored
        @(negedge clk);
        load = 1'b1;
        din  = 8'hF0;
        for (int c = 1; c <= FR + 3; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (c == 4) begin
                chk("ign ready", ready, 1'b0);
                load = 1'b1;
                din  = 8'h55;
            end
            if (c <= FR) chk($sformatf("ign x[%0d]", c), x, exp_bit(8'hF0, c));
            if (c == FR + 1) chk("ign done", done, 1'b1);
            if (c > FR) begin
                chk($sformatf("ign busy[%0d]", c), busy, 1'b0);
                chk($sformatf("ign x_idle[%0d]", c), x, 1'b0);
            end
        end

        // Asynchronous reset mid-frame during bit 3, then restart
        @(negedge clk);
        load = 1'b1;
        din  = 8'b1011_0010;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            load = 1'b0;
        end
        chk("pre_rst x", x, 1'b1);
        chk("pre_rst busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("arst x", x, 1'b0);
        chk("arst busy", busy, 1'b0);
        chk("arst done", done, 1'b0);
        chk("arst ready", ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        run_frame(8'h81, "81");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
